cpu_mem_bridge: RTL and testbench

- Sits directly downstream of the cpu memory port (addr/rd/wr/wrdata/rddata) and adapts it to a variable-latency Avalon-MM style memory master.
- Posts CPU writes into a small write buffer so stores do not stall the core. Reads are strictly ordered behind buffered writes.
- Returns read data to the core with a valid pulse, and holds the core with a stall signal while a request cannot be accepted or completed.

---
 rtl/cpu_mem_pkg.sv | 21 ++
 rtl/cpu_mem_bridge_wr_buf.sv | 74 +++++++
 rtl/cpu_mem_bridge.sv | 127 ++++++++++++
 tb/tb_cpu_mem_bridge.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the cpu_mem_bridge slice.
// Optional store-to-load forwarding: CPU_MEM_BRIDGE_FWD_EN.
package cpu_mem_pkg;

  localparam int CPU_AW = 16;
  localparam int CPU_DW = 16;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RD_REQ,
    RD_WAIT,
    RESP
  } bridge_state_t;

  typedef struct packed {
    logic [CPU_AW-1:0] addr;
    logic [CPU_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/cpu_mem_bridge_wr_buf.sv
// Posted-write FIFO; youngest-match lookup when
// CPU_MEM_BRIDGE_FWD_EN is defined.
module wr_buf
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  wb_entry_t         i_din,
  output wb_entry_t         o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
`ifdef CPU_MEM_BRIDGE_FWD_EN
  ,
  input  logic [CPU_AW-1:0] i_lk_addr,
  output logic              o_lk_hit,
  output logic [CPU_DW-1:0] o_lk_data
`endif
);

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

`ifdef CPU_MEM_BRIDGE_FWD_EN
  // Scan oldest to youngest so the last hit wins.
  always_comb begin
    o_lk_hit  = 1'b0;
    o_lk_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) &&
          (r_mem[idx].addr == i_lk_addr)) begin
        o_lk_hit  = 1'b1;
        o_lk_data = r_mem[idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/cpu_mem_bridge.sv
// CPU port to Avalon-MM bridge with posted writes and ordered reads.
// Optional store-to-load forwarding: CPU_MEM_BRIDGE_FWD_EN.
module cpu_mem_bridge
  import cpu_mem_pkg::*;
#(
  parameter int AW       = CPU_AW,
  parameter int DW       = CPU_DW,
  parameter int WB_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic          i_cpu_rd,
  input  logic          i_cpu_wr,
  input  logic [DW-1:0] i_cpu_wrdata,
  output logic [DW-1:0] o_cpu_rddata,
  output logic          o_cpu_rdvalid,
  output logic          o_cpu_stall,
  output logic [AW-1:0] o_avm_address,
  output logic          o_avm_read,
  output logic          o_avm_write,
  output logic [DW-1:0] o_avm_writedata,
  input  logic          i_avm_waitrequest,
  input  logic [DW-1:0] i_avm_readdata,
  input  logic          i_avm_readdatavalid
);

  localparam int CW = $clog2(WB_DEPTH) + 1;

  bridge_state_t r_state;
  bridge_state_t w_next;
  logic [AW-1:0] r_rd_addr;
  logic [DW-1:0] r_rddata;
  wb_entry_t     w_head;
  wb_entry_t     w_din;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_open;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_wr_bus;
  logic          w_pop;
  logic          w_fwd_hit;
  logic [DW-1:0] w_fwd_data;

  assign w_open   = (r_state == IDLE) || (r_state == RESP);
  assign w_wr_acc = w_open && i_cpu_wr && !w_full;
  assign w_rd_acc = w_open && i_cpu_rd && !i_cpu_wr;
  assign w_wr_bus = !w_empty &&
                    ((r_state == IDLE) || (r_state == DRAIN));
  assign w_pop    = w_wr_bus && !i_avm_waitrequest;
  assign w_din    = '{addr: i_cpu_addr, data: i_cpu_wrdata};

  wr_buf #(.DEPTH(WB_DEPTH)) u_wr_buf (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_wr_acc),
    .i_pop     (w_pop),
    .i_din     (w_din),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
`ifdef CPU_MEM_BRIDGE_FWD_EN
    ,
    .i_lk_addr (i_cpu_addr),
    .o_lk_hit  (w_fwd_hit),
    .o_lk_data (w_fwd_data)
`endif
  );

`ifndef CPU_MEM_BRIDGE_FWD_EN
  assign w_fwd_hit  = 1'b0;
  assign w_fwd_data = '0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, RESP: begin
        w_next = IDLE;
        if (w_rd_acc) begin
          if (w_fwd_hit)     w_next = RESP;
          else if (!w_empty) w_next = DRAIN;
          else               w_next = RD_REQ;
        end
      end
      DRAIN:   if (w_count == '0) w_next = RD_REQ;
      RD_REQ:  if (!i_avm_waitrequest) w_next = RD_WAIT;
      RD_WAIT: if (i_avm_readdatavalid) w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rd_addr <= '0;
      r_rddata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_rd_acc) r_rd_addr <= i_cpu_addr;
      if (w_rd_acc && w_fwd_hit)
        r_rddata <= w_fwd_data;
      else if ((r_state == RD_WAIT) && i_avm_readdatavalid)
        r_rddata <= i_avm_readdata;
    end
  end

  // A write alongside a read takes priority; the read is dropped.
  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(i_cpu_rd && i_cpu_wr))
      else $warning("cpu_mem_bridge: rd+wr together, read dropped");
  end

  assign o_cpu_rddata    = r_rddata;
  assign o_cpu_rdvalid   = (r_state == RESP);
  assign o_cpu_stall     = w_open ? (i_cpu_wr && w_full) : 1'b1;
  assign o_avm_read      = (r_state == RD_REQ);
  assign o_avm_write     = w_wr_bus;
  assign o_avm_address   = o_avm_read ? r_rd_addr :
                           (w_wr_bus ? w_head.addr : '0);
  assign o_avm_writedata = w_wr_bus ? w_head.data : '0;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed self-checking bench for cpu_mem_bridge.
module tb_cpu_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        rd;
  logic        wr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rdvalid;
  logic        stall;
  logic [15:0] avm_addr;
  logic        avm_rd;
  logic        avm_wr;
  logic [15:0] avm_wdata;
  logic        avm_wait;
  logic [15:0] avm_rdata;
  logic        avm_rvalid;

  int n_cmp = 0;
  int n_err = 0;

  cpu_mem_bridge dut (
    .clk                 (clk),
    .reset               (reset),
    .i_cpu_addr          (addr),
    .i_cpu_rd            (rd),
    .i_cpu_wr            (wr),
    .i_cpu_wrdata        (wdata),
    .o_cpu_rddata        (rdata),
    .o_cpu_rdvalid       (rdvalid),
    .o_cpu_stall         (stall),
    .o_avm_address       (avm_addr),
    .o_avm_read          (avm_rd),
    .o_avm_write         (avm_wr),
    .o_avm_writedata     (avm_wdata),
    .i_avm_waitrequest   (avm_wait),
    .i_avm_readdata      (avm_rdata),
    .i_avm_readdatavalid (avm_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; addr = '0; rd = 0; wr = 0; wdata = '0;
    avm_wait = 0; avm_rdata = '0; avm_rvalid = 0;
    #1;
    chk1 ("rst_stall", stall, 1'b0);
    chk1 ("rst_rdvalid", rdvalid, 1'b0);
    chk1 ("rst_avm_rd", avm_rd, 1'b0);
    chk1 ("rst_avm_wr", avm_wr, 1'b0);
    chk16("rst_addr", avm_addr, 16'h0000);
    chk16("rst_wdata", avm_wdata, 16'h0000);
    chk16("rst_rdata", rdata, 16'h0000);
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // zero-wait read of 0x0040
    rd = 1; addr = 16'h0040; #1;
    chk1 ("zr_acc_stall", stall, 1'b0);
    cyc(); rd = 0; #1;
    chk1 ("zr_req_rd", avm_rd, 1'b1);
    chk16("zr_req_addr", avm_addr, 16'h0040);
    chk1 ("zr_req_stall", stall, 1'b1);
    cyc(); avm_rvalid = 1; avm_rdata = 16'hBEEF; #1;
    chk1 ("zr_wait_rd", avm_rd, 1'b0);
    chk1 ("zr_wait_stall", stall, 1'b1);
    chk1 ("zr_wait_rdvalid", rdvalid, 1'b0);
    cyc(); avm_rvalid = 0; #1;
    chk1 ("zr_resp_rdvalid", rdvalid, 1'b1);
    chk16("zr_resp_data", rdata, 16'hBEEF);
    chk1 ("zr_resp_stall", stall, 1'b0);
    cyc();
    chk1 ("zr_pulse_end", rdvalid, 1'b0);
    chk16("zr_hold_data", rdata, 16'hBEEF);

    // write burst against a stalled bus
    avm_wait = 1;
    for (int i = 0; i < 4; i++) begin
      wr = 1; addr = 16'h0010 + 16'(i); wdata = 16'hA000 + 16'(i);
      #1;
      chk1 ("wb_acc_stall", stall, 1'b0);
      chk1 ("wb_avm_wr", avm_wr, (i != 0));
      cyc();
    end
    addr = 16'h0014; wdata = 16'hA004; #1;
    chk1 ("wb_full_stall", stall, 1'b1);
    chk16("wb_head_addr", avm_addr, 16'h0010);
    cyc();
    chk1 ("wb_full_stall2", stall, 1'b1);
    avm_wait = 0; #1;
    chk1 ("wb_pop_nounstall", stall, 1'b1);
    chk16("wb_d0_addr", avm_addr, 16'h0010);
    chk16("wb_d0_data", avm_wdata, 16'hA000);
    cyc();
    chk1 ("wb_5th_acc", stall, 1'b0);
    chk16("wb_d1_addr", avm_addr, 16'h0011);
    chk16("wb_d1_data", avm_wdata, 16'hA001);
    cyc(); wr = 0; #1;
    chk16("wb_d2_data", avm_wdata, 16'hA002);
    chk1 ("wb_mutex", avm_rd, 1'b0);
    cyc();
    chk16("wb_d3_data", avm_wdata, 16'hA003);
    cyc();
    chk16("wb_d4_addr", avm_addr, 16'h0014);
    chk16("wb_d4_data", avm_wdata, 16'hA004);
    cyc();
    chk1 ("wb_drained", avm_wr, 1'b0);

`ifndef CPU_MEM_BRIDGE_FWD_EN
    // read after write: write must reach the bus first
    wr = 1; addr = 16'h0020; wdata = 16'h1234; #1;
    chk1 ("raw_wr_acc", stall, 1'b0);
    cyc(); wr = 0; rd = 1; avm_wait = 1; #1;
    chk1 ("raw_rd_acc", stall, 1'b0);
    chk1 ("raw_bus_wr", avm_wr, 1'b1);
    chk16("raw_bus_data", avm_wdata, 16'h1234);
    cyc(); rd = 0; #1;
    chk1 ("raw_drain_stall", stall, 1'b1);
    chk1 ("raw_drain_nord", avm_rd, 1'b0);
    chk1 ("raw_drain_wr", avm_wr, 1'b1);
    avm_wait = 0;
    cyc();
    chk1 ("raw_empty_wr", avm_wr, 1'b0);
    chk1 ("raw_empty_nord", avm_rd, 1'b0);
    cyc();
    chk1 ("raw_req_rd", avm_rd, 1'b1);
    chk16("raw_req_addr", avm_addr, 16'h0020);
    cyc(); avm_rvalid = 1; avm_rdata = 16'h5678; #1;
    cyc(); avm_rvalid = 0; #1;
    chk1 ("raw_rdvalid", rdvalid, 1'b1);
    chk16("raw_rdata", rdata, 16'h5678);
    cyc();
    chk1 ("raw_pulse_end", rdvalid, 1'b0);
`else
    // forwarding from the youngest matching buffered write
    avm_wait = 1;
    wr = 1; addr = 16'h0030; wdata = 16'h1111;
    cyc(); wdata = 16'h2222; #1;
    chk1 ("fwd_wr2_stall", stall, 1'b0);
    cyc(); wr = 0; rd = 1; #1;
    chk1 ("fwd_rd_acc", stall, 1'b0);
    chk1 ("fwd_nord0", avm_rd, 1'b0);
    cyc(); rd = 0; #1;
    chk1 ("fwd_rdvalid", rdvalid, 1'b1);
    chk16("fwd_rdata", rdata, 16'h2222);
    chk1 ("fwd_nord1", avm_rd, 1'b0);
    avm_wait = 0;
    cyc(); cyc(); cyc();
    chk1 ("fwd_drained", avm_wr, 1'b0);
`endif

    // illegal rd+wr, then reset with two writes buffered
    avm_wait = 1;
    rd = 1; wr = 1; addr = 16'h0050; wdata = 16'h5555; #1;
    chk1 ("ill_stall", stall, 1'b0);
    cyc(); rd = 0; wr = 0; #1;
    chk1 ("ill_wr_queued", avm_wr, 1'b1);
    chk16("ill_addr", avm_addr, 16'h0050);
    chk16("ill_data", avm_wdata, 16'h5555);
    chk1 ("ill_no_rd", avm_rd, 1'b0);
    chk1 ("ill_idle_stall", stall, 1'b0);
    wr = 1; addr = 16'h0051; wdata = 16'h5151;
    cyc(); wr = 0; #1;
    chk16("buf2_head", avm_addr, 16'h0050);
    reset = 1; #1;
    chk1 ("rstbuf_wr", avm_wr, 1'b0);
    chk16("rstbuf_addr", avm_addr, 16'h0000);
    cyc(); reset = 0; avm_wait = 0;
    cyc();
    chk1 ("rstbuf_gone0", avm_wr, 1'b0);
    cyc();
    chk1 ("rstbuf_gone1", avm_wr, 1'b0);

    // reset while waiting for read data
    rd = 1; addr = 16'h0060; #1;
    cyc(); rd = 0; #1;
    chk1 ("rw_req_rd", avm_rd, 1'b1);
    cyc();
    chk1 ("rw_wait_stall", stall, 1'b1);
    reset = 1; #1;
    chk1 ("rw_rst_stall", stall, 1'b0);
    chk1 ("rw_rst_rd", avm_rd, 1'b0);
    chk1 ("rw_rst_wr", avm_wr, 1'b0);
    cyc(); reset = 0;
    cyc(); avm_rvalid = 1; avm_rdata = 16'hDEAD;
    cyc(); avm_rvalid = 0; #1;
    chk1 ("rw_late_rdvalid", rdvalid, 1'b0);
    chk16("rw_late_rdata", rdata, 16'h0000);
    cyc();
    chk1 ("rw_late_rdvalid2", rdvalid, 1'b0);
    chk1 ("rw_idle_stall", stall, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
